// File: rtl/xorshift_stream.sv
`default_nettype none
// ============================================================================
//  Module      : xorshift_stream
//  Description : Free-running xorshift pseudo-random generator that feeds a
//                small FIFO with a valid/ready output stream. A new word is
//                generated only when there is room for it, so no word is
//                ever lost or repeated.
//
//  Ports       : clk        - clock, rising edge
//                arst       - asynchronous active-high reset
//                en         - generator enable (state freezes when low)
//                seed_valid - load seed into the generator and flush FIFO
//                seed       - seed value (0 is replaced by RESET_STATE)
//                seed_ready - always 1
//                m_valid    - FIFO head holds a word
//                m_ready    - consumer accepts the head word
//                m_data     - word at FIFO head
//                level      - FIFO occupancy
//                gen_count  - popped-word counter (only with
//                             XORSHIFT_STREAM_CNT_EN defined)
//
//  Optional    : define XORSHIFT_STREAM_CNT_EN to add gen_count.
//  Revision    : 1.0 - initial release
// ============================================================================
module xorshift_stream #(
    parameter int               WIDTH       = 32,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_STATE = WIDTH'(1)
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       en,
    input  logic                       seed_valid,
    input  logic [WIDTH-1:0]           seed,
    output logic                       seed_ready,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_data,
    output logic [$clog2(DEPTH+1)-1:0] level
`ifdef XORSHIFT_STREAM_CNT_EN
    ,
    output logic [31:0]                gen_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] y;
        y = x;
        if (WIDTH == 64) begin
            y = y ^ (y << 13);
            y = y ^ (y >> 7);
            y = y ^ (y << 17);
        end else begin
            y = y ^ (y << 13);
            y = y ^ (y >> 17);
            y = y ^ (y << 5);
        end
        return y;
    endfunction

    logic [WIDTH-1:0] state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] next_word;
    logic             pop;
    logic             push;

    assign next_word  = step(state_q);
    assign seed_ready = 1'b1;
    assign m_valid    = (level_q != '0);
    assign m_data     = mem_q[rd_ptr_q];
    assign level      = level_q;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // push when the consumer is draining it.
    assign pop  = m_valid && m_ready;
    assign push = en && !seed_valid && ((level_q < FULL_LEVEL) || pop);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (seed_valid) begin
            // Seed load wins over everything, including a concurrent pop.
            state_d  = (seed == '0) ? RESET_STATE : seed;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                state_d  = next_word;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                level_d = level_q + LW'(1);
            end else if (pop && !push) begin
                level_d = level_q - LW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= RESET_STATE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: contents are only observed when level != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= next_word;
        end
    end

`ifdef XORSHIFT_STREAM_CNT_EN
    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (seed_valid) begin
            count_d = '0;
        end else if (pop) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign gen_count = count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xorshift_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xorshift_stream
//  Description : Self-checking bench for xorshift_stream (WIDTH=32, DEPTH=4).
//                Fixed vector table, corner-case sequences and a randomized
//                run against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xorshift_stream;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             arst = 1'b1;
    logic             en = 1'b0;
    logic             seed_valid = 1'b0;
    logic [WIDTH-1:0] seed = '0;
    logic             seed_ready;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [WIDTH-1:0] m_data;
    logic [LW-1:0]    level;
`ifdef XORSHIFT_STREAM_CNT_EN
    logic [31:0]      gen_count;
`endif

    xorshift_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_STATE(32'd1)) dut (
        .clk        (clk),
        .arst       (arst),
        .en         (en),
        .seed_valid (seed_valid),
        .seed       (seed),
        .seed_ready (seed_ready),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .level      (level)
`ifdef XORSHIFT_STREAM_CNT_EN
        ,
        .gen_count  (gen_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: generator value plus a queue of buffered words.
    logic [31:0] ms;
    logic [31:0] mq[$];
    logic [31:0] mcnt;

    function automatic logic [31:0] ref_step(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ms = 32'd1;
        mq.delete();
        mcnt = '0;
    endtask

    // One clock: apply inputs, update model at the edge, settle at negedge.
    task automatic cyc(input logic e, input logic sv, input logic [31:0] s, input logic r);
        bit p;
        bit ps;
        en = e; seed_valid = sv; seed = s; m_ready = r;
        @(posedge clk);
        if (sv) begin
            ms = (s == 0) ? 32'd1 : s;
            mq.delete();
            mcnt = '0;
        end else begin
            p  = (mq.size() != 0) && r;
            ps = e && ((mq.size() < DEPTH) || p);
            if (p) begin
                void'(mq.pop_front());
                mcnt = mcnt + 1;
            end
            if (ps) begin
                ms = ref_step(ms);
                mq.push_back(ms);
            end
        end
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_valid"}, 64'(m_valid), 64'(mq.size() != 0));
        check({tag, "_level"}, 64'(level), 64'(mq.size()));
        if (mq.size() != 0) check({tag, "_data"}, 64'(m_data), 64'(mq[0]));
`ifdef XORSHIFT_STREAM_CNT_EN
        check({tag, "_cnt"}, 64'(gen_count), 64'(mcnt));
`endif
    endtask

    typedef struct {
        logic        en;
        logic        sv;
        logic [31:0] seed;
        logic        rdy;
        logic        exp_valid;
        logic [2:0]  exp_level;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vt[12];

    initial begin
        vt[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 3'd1, 1'b1, 32'h00042021};
        vt[1]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 3'd2, 1'b1, 32'h00042021};
        vt[2]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 3'd3, 1'b1, 32'h00042021};
        vt[3]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 3'd4, 1'b1, 32'h00042021};
        vt[4]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 3'd4, 1'b1, 32'h00042021};
        vt[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 3'd3, 1'b1, 32'h04080601};
        vt[6]  = '{1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 3'd0, 1'b0, 32'h0};
        vt[7]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 3'd1, 1'b1, 32'h00042021};
        vt[8]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 3'd1, 1'b1, 32'h00042021};
        vt[9]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 3'd2, 1'b1, 32'h00042021};
        vt[10] = '{1'b1, 1'b1, 32'h12345678, 1'b1, 1'b0, 3'd0, 1'b0, 32'h0};
        vt[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 3'd0, 1'b0, 32'h0};

        model_reset();
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("seed_ready", 64'(seed_ready), 64'd1);
`ifdef XORSHIFT_STREAM_CNT_EN
        check("rst_cnt", 64'(gen_count), 64'd0);
`endif
        arst = 1'b0;
        @(negedge clk);

        // Fixed vectors.
        for (int i = 0; i < 12; i++) begin
            cyc(vt[i].en, vt[i].sv, vt[i].seed, vt[i].rdy);
            check($sformatf("vec%0d_valid", i), 64'(m_valid), 64'(vt[i].exp_valid));
            check($sformatf("vec%0d_level", i), 64'(level), 64'(vt[i].exp_level));
            if (vt[i].chk_data)
                check($sformatf("vec%0d_data", i), 64'(m_data), 64'(vt[i].exp_data));
        end

        // Streaming from a fresh seed of 1: 0x00042021 then 0x04080601.
        cyc(1'b0, 1'b1, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("stream_w0", 64'(m_data), 64'h00042021);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("stream_w1", 64'(m_data), 64'h04080601);

        // Stall for 10 cycles, then drain continuously while full.
        cyc(1'b0, 1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
        check("stall_level", 64'(level), 64'd4);
        check("stall_data", 64'(m_data), 64'h00042021);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 32'h0, 1'b1);
            check("full_level", 64'(level), 64'd4);
            check_model("full");
        end

        // Randomized run against the model.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] s;
            s = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0, s,
                $urandom_range(0, 1) == 1);
            check_model("rand");
        end

        // Asynchronous reset mid-stream with two words buffered.
        cyc(1'b0, 1'b1, 32'hdeadbeef, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        check("pre_arst_level", 64'(level), 64'd2);
        #2;
        arst = 1'b1;
        #1;
        check("arst_valid", 64'(m_valid), 64'd0);
        check("arst_level", 64'(level), 64'd0);
`ifdef XORSHIFT_STREAM_CNT_EN
        check("arst_cnt", 64'(gen_count), 64'd0);
`endif
        model_reset();
        @(negedge clk);
        arst = 1'b0;
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("post_arst_data", 64'(m_data), 64'h00042021);
        check_model("post_arst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
